mem32_block_reader: RTL and testbench
=====================================

MEM32_BLOCK_READER -- requirements
Module: mem32_block_reader

Interface
REQ-001 SHALL have parameter TAG, default 8'h11, the tag driven on mem32_tag and matched on dack/rack tags; never 8'h00.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the output FIFO depth in words; power of two, 2..16.
REQ-003 clock  in  1  single clock; all logic rising-edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  one-cycle pulse that begins a transfer; honoured only when busy=0.
REQ-006 start_addr  in  26  byte address of the first word; bits [1:0] ignored and treated as 0.
REQ-007 word_count  in  16  number of 32-bit words to read; sampled with start.
REQ-008 busy  out  1  high from the cycle after an accepted start until done.
REQ-009 done  out  1  one-cycle pulse when a transfer completes.
REQ-010 mem32_address  out  26  request address, word aligned.
REQ-011 mem32_direction  out  1  constant 0 (read).
REQ-012 mem32_byte_en  out  4  constant 4'hF.
REQ-013 mem32_wdata  out  32  constant 0.
REQ-014 mem32_request  out  1  request valid, held until accepted.
REQ-015 mem32_tag  out  8  TAG while mem32_request=1, else 8'h00.
REQ-016 mem32_dack_tag  in  8  accept; request accepted in a cycle with mem32_request=1 and mem32_dack_tag==TAG.
REQ-017 mem32_rdata  in  32  read data.
REQ-018 mem32_rack  in  1  read data valid.
REQ-019 mem32_rack_tag  in  8  tag of the returned data; only ==TAG is consumed.
REQ-020 out_data  out  32  FIFO head word.
REQ-021 out_valid  out  1  FIFO not empty.
REQ-022 out_ready  in  1  sink accept; a word pops when out_valid=1 and out_ready=1.

Function
REQ-023 SHALL implement states IDLE, ISSUE and DRAIN.
REQ-024 IDLE, start=1, word_count>0: latch the address (bits [1:0]=0) and the count, set busy, go to ISSUE.
REQ-025 IDLE, start=1, word_count=0: issue no request, pulse done in the next cycle, stay in IDLE, busy stays 0.
REQ-026 ISSUE: assert mem32_request only while credit holds: fifo_level + outstanding < FIFO_DEPTH.
REQ-027 outstanding counts accepted requests not yet returned by a matching rack.
REQ-028 Once mem32_request is asserted, it and mem32_address SHALL stay stable until accepted, regardless of credit.
REQ-029 On accept: address += 4 modulo 2^26 (0x3FFFFFC wraps to 0x0000000), requests_left -= 1, outstanding += 1.
REQ-030 mem32_request MAY re-assert in the cycle after an accept; back-to-back issue when credit allows.
REQ-031 When the last request is accepted, go to DRAIN.
REQ-032 On mem32_rack=1 with mem32_rack_tag==TAG: write mem32_rdata into the FIFO the same cycle, outstanding -= 1.
REQ-033 Returned data SHALL be in-order: FIFO order equals request order.
REQ-034 Racks with mismatched tag SHALL be ignored; dack tags that do not match SHALL not count as an accept.
REQ-035 Accept and matching rack in the same cycle: outstanding unchanged.
REQ-036 Push and pop in the same cycle: FIFO level unchanged; a pop from an empty FIFO never occurs.
REQ-037 Credit rule SHALL guarantee that no FIFO overflow occurs; a matching rack with no outstanding request is ignored.
REQ-038 DRAIN, outstanding=0: pulse done in the following cycle, clear busy with done, return to IDLE.
REQ-039 The FIFO may still hold words after done; draining it via out_ready continues in IDLE.
REQ-040 start while busy=1 SHALL be ignored.
REQ-041 A start in the same cycle as done SHALL be ignored.

Reset
REQ-042 While reset_n=0 and on release, the following SHALL be 0: mem32_request, mem32_tag, mem32_address, busy, done, out_valid and out_data.
REQ-043 Reset SHALL also empty the FIFO, clear outstanding and requests_left, and put the state machine in IDLE.
REQ-044 Reset during a transfer abandons it with no done; racks arriving after release are ignored.

Verification
REQ-045 start_addr=0x100, count=3, dack 1 cycle after request, rack 2 cycles later, out_ready=1 -> requests at 0x100/0x104/0x108, out words in order, exactly one done.
REQ-046 count=8, out_ready=0, FIFO_DEPTH=4 -> exactly 4 accepts then request low; each pop enables one more accept; done after 8 racks.
REQ-047 Rack with tag 0x22 interleaved -> ignored; level and outstanding unchanged.
REQ-048 start with count=0 -> no mem32_request, done high exactly one cycle after start, busy stays 0.
REQ-049 start_addr=0x3FFFFFE, count=2 -> requests at 0x3FFFFFC then 0x0000000.
REQ-050 reset_n low mid-ISSUE with 2 outstanding -> all outputs 0 asynchronously; later racks ignored; a new start works normally.

Source files
------------

// File: rtl/mem32_block_reader_if.sv
// Request/acknowledge bus between the block reader (master) and a tagged 32-bit memory port (slave).
interface mem32_block_reader_if;
  logic [25:0] mem32_address;
  logic        mem32_direction;
  logic [3:0]  mem32_byte_en;
  logic [31:0] mem32_wdata;
  logic        mem32_request;
  logic [7:0]  mem32_tag;
  logic [7:0]  mem32_dack_tag;
  logic [31:0] mem32_rdata;
  logic        mem32_rack;
  logic [7:0]  mem32_rack_tag;

  modport master (
    output mem32_address, mem32_direction, mem32_byte_en, mem32_wdata,
    output mem32_request, mem32_tag,
    input  mem32_dack_tag, mem32_rdata, mem32_rack, mem32_rack_tag
  );

  modport slave (
    input  mem32_address, mem32_direction, mem32_byte_en, mem32_wdata,
    input  mem32_request, mem32_tag,
    output mem32_dack_tag, mem32_rdata, mem32_rack, mem32_rack_tag
  );
endinterface

// File: rtl/mem32_block_reader.sv
// Reads a block of consecutive 32-bit words over a tagged memory port into an output FIFO,
// issuing requests only while returned data is guaranteed a free FIFO slot.
module mem32_block_reader #(
  parameter logic [7:0]  TAG        = 8'h11,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [25:0] start_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  mem32_block_reader_if.master bus,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = LW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   left_q, left_d;
  logic [LW-1:0]   outstanding_q, outstanding_d;
  logic [LW-1:0]   level_q, level_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DW-1:0]   fifo_q [FIFO_DEPTH];
  logic            req_q, req_d;
  logic [7:0]      tag_q, tag_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q;

  logic accept_c, rack_hit_c, pop_c, start_ok_c, credit_c;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^start_addr[1:0];

  // Handshake qualifiers; a matching rack with nothing outstanding is dropped.
  assign accept_c   = req_q && (bus.mem32_dack_tag == TAG);
  assign rack_hit_c = bus.mem32_rack && (bus.mem32_rack_tag == TAG) && (outstanding_q != '0);
  assign pop_c      = valid_q && out_ready;
  assign start_ok_c = (state_q == IDLE) && start && !done_q;

  assign level_d       = level_q + LW'(rack_hit_c) - LW'(pop_c);
  assign outstanding_d = outstanding_q + LW'(accept_c) - LW'(rack_hit_c);
  // Credit evaluated on next-cycle occupancy so a newly raised request always has a slot.
  assign credit_c      = (SW'(level_d) + SW'(outstanding_d)) < SW'(FIFO_DEPTH);

  always_ff @(posedge clock or negedge reset_n) begin : state_reg
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok_c && (word_count != '0)) state_d = ISSUE;
      ISSUE:   if (accept_c && (left_q == CW'(1)))   state_d = DRAIN;
      DRAIN:   if (outstanding_q == '0)              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : output_comb
    addr_d = addr_q;
    left_d = left_q;
    req_d  = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok_c) begin
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d = {start_addr[AW-1:2], 2'b00};
            left_d = word_count;
            busy_d = 1'b1;
            req_d  = credit_c;
          end
        end
      end
      ISSUE: begin
        if (accept_c) begin
          addr_d = addr_q + AW'(4);
          left_d = left_q - CW'(1);
        end
        // A raised request is held until accepted, independent of credit.
        if (req_q && !accept_c) req_d = 1'b1;
        else                    req_d = (left_d != '0) && credit_c;
      end
      DRAIN: begin
        if (outstanding_q == '0) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
    tag_d = req_d ? TAG : 8'h00;
  end

  always_ff @(posedge clock or negedge reset_n) begin : ctrl_reg
    if (!reset_n) begin
      addr_q        <= '0;
      left_q        <= '0;
      outstanding_q <= '0;
      req_q         <= 1'b0;
      tag_q         <= 8'h00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      left_q        <= left_d;
      outstanding_q <= outstanding_d;
      req_q         <= req_d;
      tag_q         <= tag_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Output FIFO; depth is a power of two so the pointers wrap naturally.
  always_ff @(posedge clock or negedge reset_n) begin : fifo_reg
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (rack_hit_c) begin
        fifo_q[wr_ptr_q] <= bus.mem32_rdata;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
      valid_q <= (level_d != '0);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_data  = fifo_q[rd_ptr_q];

  assign bus.mem32_address   = addr_q;
  assign bus.mem32_direction = 1'b0;
  assign bus.mem32_byte_en   = 4'hF;
  assign bus.mem32_wdata     = '0;
  assign bus.mem32_request   = req_q;
  assign bus.mem32_tag       = tag_q;

endmodule

// File: tb/tb_mem32_block_reader.sv
// Directed bench for mem32_block_reader with a tagged memory responder and output monitor.
module tb_mem32_block_reader;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [25:0] start_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  mem32_block_reader_if bus ();

  mem32_block_reader #(.TAG(8'h11), .FIFO_DEPTH(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .bus        (bus),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Responder knobs and logs
  int          dack_delay = 1;
  int          rack_delay = 2;
  logic        bad_dack   = 1'b0;
  logic        bad_rack   = 1'b0;
  int          cyc        = 0;
  int          done_cnt   = 0;
  int          req_seen   = 0;
  int          age        = 0;
  logic [25:0] dack_addr  = '0;
  logic [25:0] acc_addr [$];
  logic [31:0] out_log  [$];
  logic [25:0] pend_addr[$];
  int          pend_due [$];

  // Memory responder and monitors, all acting at the falling edge.
  initial begin : bfm
    bus.mem32_dack_tag = 8'h00;
    bus.mem32_rack     = 1'b0;
    bus.mem32_rack_tag = 8'h00;
    bus.mem32_rdata    = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (out_valid && out_ready) out_log.push_back(out_data);
      if (done) done_cnt++;
      if (bus.mem32_request) req_seen++;
      if (!reset_n) begin
        bus.mem32_dack_tag = 8'h00;
        age = 0;
      end else if (bus.mem32_dack_tag == 8'h11) begin
        acc_addr.push_back(dack_addr);
        pend_addr.push_back(dack_addr);
        pend_due.push_back(cyc + rack_delay);
        bus.mem32_dack_tag = 8'h00;
        age = 0;
      end else if (bus.mem32_request) begin
        age++;
        if (age > dack_delay) begin
          bus.mem32_dack_tag = 8'h11;
          dack_addr = bus.mem32_address;
        end else begin
          bus.mem32_dack_tag = bad_dack ? 8'h22 : 8'h00;
        end
      end else begin
        bus.mem32_dack_tag = 8'h00;
      end
      bus.mem32_rack     = 1'b0;
      bus.mem32_rack_tag = 8'h00;
      bus.mem32_rdata    = '0;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        bus.mem32_rack     = 1'b1;
        bus.mem32_rack_tag = 8'h11;
        bus.mem32_rdata    = {6'h2A, pend_addr[0]};
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else if (bad_rack) begin
        bus.mem32_rack     = 1'b1;
        bus.mem32_rack_tag = 8'h22;
        bus.mem32_rdata    = 32'hDEAD_BEEF;
        bad_rack = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_addr.size()) ? 32'(acc_addr[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] out_at(input int i);
    return (i < out_log.size()) ? out_log[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_logs();
    acc_addr.delete();
    out_log.delete();
    done_cnt = 0;
    req_seen = 0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(done_cnt != base), 32'd1);
  endtask

  task automatic go(input logic [25:0] a, input logic [15:0] n);
    start_addr = a;
    word_count = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    word_count = '0;
  endtask

  initial begin : main
    int n;
    reset_n = 1'b0;
    start = 1'b0;
    start_addr = '0;
    word_count = '0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_request",   32'(bus.mem32_request),   32'd0);
    chk("rst_tag",       32'(bus.mem32_tag),       32'd0);
    chk("rst_address",   32'(bus.mem32_address),   32'd0);
    chk("rst_busy",      32'(busy),                32'd0);
    chk("rst_done",      32'(done),                32'd0);
    chk("rst_out_valid", 32'(out_valid),           32'd0);
    chk("rst_out_data",  out_data,                 32'd0);
    chk("rst_direction", 32'(bus.mem32_direction), 32'd0);
    chk("rst_byte_en",   32'(bus.mem32_byte_en),   32'hF);
    chk("rst_wdata",     bus.mem32_wdata,          32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Basic three-word transfer
    clear_logs();
    go(26'h100, 16'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_tag_vs_req", 32'(bus.mem32_tag), bus.mem32_request ? 32'h11 : 32'h00);
    wait_done(200, "t1_done_seen");
    repeat (4) tick();
    chk("t1_acc_cnt", 32'(acc_addr.size()), 32'd3);
    chk("t1_addr0", acc_at(0), 32'h100);
    chk("t1_addr1", acc_at(1), 32'h104);
    chk("t1_addr2", acc_at(2), 32'h108);
    chk("t1_out_cnt", 32'(out_log.size()), 32'd3);
    chk("t1_word0", out_at(0), 32'hA800_0100);
    chk("t1_word1", out_at(1), 32'hA800_0104);
    chk("t1_word2", out_at(2), 32'hA800_0108);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // Credit limit with a stalled sink, plus a foreign-tag rack
    clear_logs();
    out_ready = 1'b0;
    go(26'h2000, 16'd8);
    repeat (30) tick();
    chk("t3_acc_cnt4", 32'(acc_addr.size()), 32'd4);
    chk("t3_req_low", 32'(bus.mem32_request), 32'd0);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_head", out_data, 32'hA800_2000);
    bad_rack = 1'b1;
    repeat (5) tick();
    chk("t3_head_after_bad", out_data, 32'hA800_2000);
    chk("t3_acc_after_bad", 32'(acc_addr.size()), 32'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (10) tick();
    chk("t3_acc_cnt5", 32'(acc_addr.size()), 32'd5);
    chk("t3_one_pop", 32'(out_log.size()), 32'd1);
    chk("t3_req_low2", 32'(bus.mem32_request), 32'd0);
    out_ready = 1'b1;
    wait_done(400, "t3_done_seen");
    repeat (6) tick();
    chk("t3_acc_cnt8", 32'(acc_addr.size()), 32'd8);
    chk("t3_out_cnt", 32'(out_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("t3_word%0d", i), out_at(i), 32'hA800_2000 + 32'(4 * i));
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);

    // Zero-length start, then a start coinciding with done
    clear_logs();
    go(26'h300, 16'd0);
    chk("t4_done_pulse", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    go(26'h300, 16'd5);
    chk("t4_done_low", 32'(done), 32'd0);
    chk("t4_start_ignored", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("t4_no_request", 32'(req_seen), 32'd0);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Address wrap with foreign dack tags while waiting
    clear_logs();
    dack_delay = 2;
    bad_dack = 1'b1;
    go(26'h3FF_FFFE, 16'd2);
    wait_done(200, "t5_done_seen");
    repeat (4) tick();
    bad_dack = 1'b0;
    dack_delay = 1;
    chk("t5_acc_cnt", 32'(acc_addr.size()), 32'd2);
    chk("t5_addr0", acc_at(0), 32'h3FF_FFFC);
    chk("t5_addr1", acc_at(1), 32'h000_0000);
    chk("t5_word0", out_at(0), 32'hABFF_FFFC);
    chk("t5_word1", out_at(1), 32'hA800_0000);

    // Reset mid-transfer with requests outstanding
    clear_logs();
    rack_delay = 20;
    go(26'h4000, 16'd6);
    n = 0;
    while (acc_addr.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("t6_two_outstanding", 32'(acc_addr.size() >= 2), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_request",   32'(bus.mem32_request), 32'd0);
    chk("t6_rst_tag",       32'(bus.mem32_tag),     32'd0);
    chk("t6_rst_address",   32'(bus.mem32_address), 32'd0);
    chk("t6_rst_busy",      32'(busy),              32'd0);
    chk("t6_rst_out_valid", 32'(out_valid),         32'd0);
    chk("t6_rst_out_data",  out_data,               32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    clear_logs();
    n = 0;
    while (pend_due.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("t6_stale_racks_sent", 32'(pend_due.size()), 32'd0);
    repeat (3) tick();
    chk("t6_stale_ignored", 32'(out_log.size()), 32'd0);
    chk("t6_valid_low", 32'(out_valid), 32'd0);
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    chk("t6_busy_low", 32'(busy), 32'd0);
    rack_delay = 2;
    go(26'h40, 16'd2);
    wait_done(200, "t6_restart_done");
    repeat (4) tick();
    chk("t6_addr0", acc_at(0), 32'h40);
    chk("t6_addr1", acc_at(1), 32'h44);
    chk("t6_word0", out_at(0), 32'hA800_0040);
    chk("t6_word1", out_at(1), 32'hA800_0044);
    chk("t6_out_cnt", 32'(out_log.size()), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
